adder_result_sequencer: RTL

Controller between the UART receive path, the four 64-bit adders (CLA, carry-skip, ripple, carry-select) and the byte-wide UART transmitter. Latches operand pairs from received frames and arbitrates the four push-button requests into one adder selection. After a fixed settle time it captures the chosen sum and serializes an 11-byte response frame (header, sum, checksum) one byte at a time over a start/busy handshake.

---
 rtl/adder_seq_pkg.sv | 43 ++++
 rtl/adder_result_sequencer_if.sv | 14 +
 rtl/adder_result_sequencer_btn_edge_sync.sv | 46 ++++
 rtl/adder_result_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg
// Shared definitions for the adder result sequencer: FSM state encoding,
// adder-select codes, response frame geometry, default header and the
// response checksum helper.
// Build option: FULL_CHECKSUM_EN selects the checksum over all ten header and
// sum bytes; when undefined the checksum is (HEADER[7:0] + sum[7:0]) mod 256.
package adder_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    localparam logic [1:0] SEL_CLA  = 2'd0;
    localparam logic [1:0] SEL_CSA  = 2'd1;
    localparam logic [1:0] SEL_RA   = 2'd2;
    localparam logic [1:0] SEL_CSLA = 2'd3;

    localparam int unsigned FRAME_BYTES    = 11;
    localparam logic [3:0]  LAST_IDX       = 4'd10;
    localparam logic [15:0] DEFAULT_HEADER = 16'hBAFD;

    // Checksum byte appended after the header and the eight sum bytes.
    function automatic logic [7:0] frame_checksum(input logic [15:0] header,
                                                  input logic [63:0] sum);
        logic [7:0] acc;
`ifdef FULL_CHECKSUM_EN
        acc = header[15:8] + header[7:0];
        for (int unsigned i = 0; i < 8; i++) begin
            acc = acc + sum[i*8 +: 8];
        end
`else
        acc = header[7:0] + sum[7:0];
`endif
        return acc;
    endfunction

endpackage

// File: rtl/adder_result_sequencer_if.sv
// adder_result_sequencer_if
// Byte-wide transmit handshake between the sequencer and the UART transmitter.
//   tx_data_o   byte to transmit (sequencer -> transmitter)
//   tx_start_o  one-cycle transmit request (sequencer -> transmitter)
//   tx_busy_i   transmitter busy (transmitter -> sequencer)
// master: sequencer side; slave: transmitter side.
interface adder_result_sequencer_if;
    logic [7:0] tx_data_o;
    logic       tx_start_o;
    logic       tx_busy_i;

    modport master (output tx_data_o, output tx_start_o, input tx_busy_i);
    modport slave  (input tx_data_o, input tx_start_o, output tx_busy_i);
endinterface

// File: rtl/adder_result_sequencer_btn_edge_sync.sv
// btn_edge_sync
// Two-flop synchronizer, rising-edge detector and fixed-priority encoder for
// the four push buttons.
//   clk, rst  clock, asynchronous active-high reset
//   btn       raw buttons [0] left, [1] up, [2] right, [3] down
//   req       one-cycle request pulse (any synchronized rising edge)
//   sel       winning adder: left > up > right > down
module btn_edge_sync
    import adder_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    output logic       req,
    output logic [1:0] sel
);

    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] prev;
    logic [3:0] rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    always_comb begin
        req = |rise;
        sel = SEL_CLA;
        if (rise[0])      sel = SEL_CLA;
        else if (rise[1]) sel = SEL_CSA;
        else if (rise[2]) sel = SEL_RA;
        else if (rise[3]) sel = SEL_CSLA;
    end

endmodule

// File: rtl/adder_result_sequencer.sv
// adder_result_sequencer
// Latches operand pairs from received UART frames, arbitrates button requests
// into an adder selection, waits SETTLE_CYCLES, captures the selected 64-bit
// sum and sends an 11-byte response (header, sum MSB first, checksum) over the
// transmit handshake.
// Build option: FULL_CHECKSUM_EN (see adder_seq_pkg) selects the checksum form.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rx_frame_i      [127:64] operand A, [63:0] operand B, [151:128] ignored
//   rx_done_i       one-cycle pulse, rx_frame_i valid
//   btn_i           raw buttons [0] CLA, [1] CSA, [2] RA, [3] CSLA
//   sum_i           adder results {csla, ra, csa, cla}
//   operand_a_o/b_o operands to all adders
//   sel_o           selected adder
//   tx              transmit handshake (master modport)
//   busy_o          frame in progress
//   frame_done_o    one-cycle pulse after the last byte completes
module adder_result_sequencer
    import adder_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [15:0] HEADER        = DEFAULT_HEADER
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [151:0]                    rx_frame_i,
    input  logic                            rx_done_i,
    input  logic [3:0]                      btn_i,
    input  logic [255:0]                    sum_i,
    output logic [63:0]                     operand_a_o,
    output logic [63:0]                     operand_b_o,
    output logic [1:0]                      sel_o,
    adder_result_sequencer_if.master        tx,
    output logic                            busy_o,
    output logic                            frame_done_o
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t      state;
    state_t      state_n;
    logic        req;
    logic [1:0]  req_sel;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [63:0] pend_a;
    logic [63:0] pend_b;
    logic        pend;
    logic [1:0]  sel_q;
    logic [7:0]  cnt;
    logic [3:0]  idx;
    logic [63:0] sum_q;
    logic [7:0]  chk_q;
    logic        busy_q;
    logic [63:0] sel_slice;
    logic [7:0]  byte_mux;
    logic        unused_rx_bits;

    assign unused_rx_bits = ^rx_frame_i[151:128];

    btn_edge_sync u_btn (
        .clk (clk),
        .rst (rst),
        .btn (btn_i),
        .req (req),
        .sel (req_sel)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state logic. WAIT_ACK advances only on a low-to-high transition of
    // tx_busy_i, so a transmitter still busy at SEND time is not mistaken for
    // an acknowledge.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:      if (req) state_n = S_SETTLE;
            S_SETTLE:    if (cnt == '0) state_n = S_CAPTURE;
            S_CAPTURE:   state_n = S_SEND;
            S_SEND:      state_n = S_WAIT_ACK;
            S_WAIT_ACK:  if (tx.tx_busy_i && !busy_q) state_n = S_WAIT_DONE;
            S_WAIT_DONE: if (!tx.tx_busy_i) state_n = (idx == LAST_IDX) ? S_DONE : S_SEND;
            S_DONE:      state_n = S_IDLE;
            default:     state_n = S_IDLE;
        endcase
    end

    always_comb begin
        case (sel_q)
            SEL_CSA:  sel_slice = sum_i[127:64];
            SEL_RA:   sel_slice = sum_i[191:128];
            SEL_CSLA: sel_slice = sum_i[255:192];
            default:  sel_slice = sum_i[63:0];
        endcase
    end

    // Datapath: operands with one-deep pending frame, select, settle counter,
    // captured sum/checksum and byte index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            pend_a <= '0;
            pend_b <= '0;
            pend   <= 1'b0;
            sel_q  <= SEL_CLA;
            cnt    <= '0;
            idx    <= '0;
            sum_q  <= '0;
            chk_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            busy_q <= tx.tx_busy_i;

            if (state == S_IDLE) begin
                if (rx_done_i) begin
                    op_a <= rx_frame_i[127:64];
                    op_b <= rx_frame_i[63:0];
                    pend <= 1'b0;
                end else if (pend) begin
                    op_a <= pend_a;
                    op_b <= pend_b;
                    pend <= 1'b0;
                end
            end else if (rx_done_i) begin
                pend_a <= rx_frame_i[127:64];
                pend_b <= rx_frame_i[63:0];
                pend   <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (req) begin
                        sel_q <= req_sel;
                        cnt   <= SETTLE_LOAD;
                    end
                end
                S_SETTLE: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                S_CAPTURE: begin
                    sum_q <= sel_slice;
                    chk_q <= frame_checksum(HEADER, sel_slice);
                    idx   <= '0;
                end
                S_WAIT_DONE: begin
                    if (!tx.tx_busy_i && idx != LAST_IDX) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (idx)
            4'd0:    byte_mux = HEADER[15:8];
            4'd1:    byte_mux = HEADER[7:0];
            4'd2:    byte_mux = sum_q[63:56];
            4'd3:    byte_mux = sum_q[55:48];
            4'd4:    byte_mux = sum_q[47:40];
            4'd5:    byte_mux = sum_q[39:32];
            4'd6:    byte_mux = sum_q[31:24];
            4'd7:    byte_mux = sum_q[23:16];
            4'd8:    byte_mux = sum_q[15:8];
            4'd9:    byte_mux = sum_q[7:0];
            default: byte_mux = chk_q;
        endcase
    end

    // Output logic
    always_comb begin
        tx.tx_start_o = (state == S_SEND);
        tx.tx_data_o  = '0;
        if (state == S_SEND || state == S_WAIT_ACK || state == S_WAIT_DONE) begin
            tx.tx_data_o = byte_mux;
        end
        busy_o       = (state != S_IDLE);
        frame_done_o = (state == S_DONE);
        sel_o        = sel_q;
        operand_a_o  = op_a;
        operand_b_o  = op_b;
    end

endmodule
